// File: rtl/uart_rx_byte_if.sv
// rtl/uart_rx_byte_if.sv - received-byte strobe bundle for uart_rx_byte
interface uart_rx_byte_if;
  logic       o_wr;
  logic [7:0] o_data;
  logic       o_frame_err;
  logic       o_parity_err;

  modport master (
    output o_wr,
    output o_data,
    output o_frame_err,
    output o_parity_err
  );

  modport slave (
    input o_wr,
    input o_data,
    input o_frame_err,
    input o_parity_err
  );
endinterface

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver, one strobe per byte; UART_RX_PARITY_EN selects 8E1
module uart_rx_byte #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_uart_rx,
  uart_rx_byte_if.master rx
);

  localparam logic [23:0] FULL = CLOCKS_PER_BAUD - 24'd1;
  localparam logic [23:0] HALF = (CLOCKS_PER_BAUD - 24'd1) >> 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  logic        rx_meta, rx_s;
  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  data_q, data_n;
  logic        wr_q, wr_n;
  logic        ferr_q, ferr_n;
  logic        sample;

`ifdef UART_RX_PARITY_EN
  logic        par_bad, par_bad_n;
  logic        perr_q, perr_n;
`endif

  // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // State, baud counter, shift register and registered output strobes
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= S_IDLE;
      cnt    <= 24'd0;
      idx    <= 3'd0;
      shift  <= 8'h00;
      data_q <= 8'h00;
      wr_q   <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shift  <= shift_n;
      data_q <= data_n;
      wr_q   <= wr_n;
      ferr_q <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
      perr_q  <= perr_n;
`endif
    end
  end

  assign sample = (cnt == 24'd0);

  // Next-state logic: sample on counter zero, reload the counter for the state being entered
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data_q;
    wr_n    = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // Falling edge seen: wait half a bit to land mid start bit
        if (!rx_s) begin
          cnt_n   = HALF;
          state_n = S_START;
        end
      end
      S_START: begin
        if (!sample) begin
          cnt_n = cnt - 24'd1;
        end else if (rx_s) begin
          // Line went back high before mid start bit: treat as a glitch
          cnt_n   = 24'd0;
          state_n = S_IDLE;
        end else begin
          cnt_n   = FULL;
          idx_n   = 3'd0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (!sample) begin
          cnt_n = cnt - 24'd1;
        end else begin
          // LSB arrives first, so shifting in at the MSB leaves bit 0 in place after 8 samples
          shift_n = {rx_s, shift[7:1]};
          cnt_n   = FULL;
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!sample) begin
          cnt_n = cnt - 24'd1;
        end else begin
          par_bad_n = ^{shift, rx_s};
          cnt_n     = FULL;
          state_n   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!sample) begin
          cnt_n = cnt - 24'd1;
        end else begin
          data_n = shift;
          cnt_n  = 24'd0;
`ifdef UART_RX_PARITY_EN
          perr_n = par_bad;
`endif
          // Leave at mid stop bit so a back-to-back start edge is not missed
          if (rx_s) begin
            wr_n    = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Swallow a held-low line until it returns to idle
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        cnt_n   = 24'd0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign rx.o_wr        = wr_q;
  assign rx.o_data      = data_q;
  assign rx.o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx.o_parity_err = perr_q;
`else
  assign rx.o_parity_err = 1'b0;
`endif

endmodule
